// File: rtl/mem_dma_pkg.sv
// Shared definitions for the memory-to-memory DMA engine: FSM encoding,
// word stride and default widths.
package mem_dma_pkg;

  localparam int WORD_BYTES = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_t;

  // A byte address is usable as a transfer base only on a word boundary.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_dma_addr_gen.sv
// Source/destination pointer pair and remaining-word counter.
// load captures the transfer description; step advances both pointers by one
// word and consumes one count. last flags the final word of the block.
module mem_dma_addr_gen
  import mem_dma_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [31:0]      src_init,
  input  logic [31:0]      dst_init,
  input  logic [CNT_W-1:0] count_init,
  output logic [31:0]      src_ptr,
  output logic [31:0]      dst_ptr,
  output logic [CNT_W-1:0] remaining,
  output logic             last
);

  // Pointers wrap naturally modulo 2^32; the memory aliases the upper bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
    end else if (load) begin
      src_ptr   <= src_init;
      dst_ptr   <= dst_init;
      remaining <= count_init;
    end else if (step) begin
      src_ptr   <= src_ptr + 32'(WORD_BYTES);
      dst_ptr   <= dst_ptr + 32'(WORD_BYTES);
      remaining <= remaining - CNT_W'(1);
    end
  end

  // Final word when exactly one count is left before this step.
  always_comb begin
    last = (remaining == CNT_W'(1));
  end

endmodule

// File: rtl/mem_dma_engine.sv
// Block-copy bus initiator for the word-addressed single-port data memory.
// One READ cycle then one WRITE cycle per word, strictly forward.
// Optional feature macro: MEM_DMA_CHECKSUM_EN adds a running sum of copied
// words on the checksum port.
//
// Handshake: start is a level request sampled only in IDLE; the engine
// answers with either a one-cycle error pulse (misaligned, nothing accessed)
// or a one-cycle done pulse after the copy. Inputs are only captured on the
// accepting edge and are not looked at again until the next IDLE.
module mem_dma_engine
  import mem_dma_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output dma_state_t        dbg_state,
  output logic [ADDR_W-1:0] dbg_word_idx
`ifdef MEM_DMA_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  dma_state_t        state_q;
  dma_state_t        state_d;
  logic              error_q;
  logic              error_d;
  logic              load;
  logic              step;
  logic              accept;
  logic [DATA_W-1:0] data_buf_q;
  logic [31:0]       src_ptr;
  logic [31:0]       dst_ptr;
  logic [CNT_W-1:0]  remaining;
  logic              last;

  mem_dma_addr_gen #(
    .CNT_W (CNT_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .src_init   (src_addr),
    .dst_init   (dst_addr),
    .count_init (word_count),
    .src_ptr    (src_ptr),
    .dst_ptr    (dst_ptr),
    .remaining  (remaining),
    .last       (last)
  );

  // State and error-pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
    end
  end

  // Next-state logic and pointer-block control.
  always_comb begin
    state_d = state_q;
    error_d = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!is_word_aligned(src_addr) || !is_word_aligned(dst_addr)) begin
            error_d = 1'b1;
          end else if (word_count == '0) begin
            accept  = 1'b1;
            state_d = ST_DONE;
          end else begin
            accept  = 1'b1;
            load    = 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        step    = 1'b1;
        state_d = last ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Word buffer; memory data is only captured while read is driven.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_buf_q <= '0;
    end else if (state_q == ST_READ) begin
      data_buf_q <= mem_rdata;
    end
  end

`ifdef MEM_DMA_CHECKSUM_EN
  // Running sum of written words; cleared on accepted start, held after done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (state_q == ST_WRITE) begin
      checksum <= checksum + data_buf_q;
    end
  end
`else
  // No checksum: accept only qualifies the pointer load path.
`endif

  // Memory port and status decode straight from the state register, so an
  // asynchronous reset drops mem_write before the next edge can land a word.
  always_comb begin
    busy        = (state_q == ST_READ) || (state_q == ST_WRITE);
    done        = (state_q == ST_DONE);
    error       = error_q;
    mem_read    = (state_q == ST_READ);
    mem_write   = (state_q == ST_WRITE);
    mem_address = '0;
    mem_wdata   = '0;
    if (state_q == ST_READ) begin
      mem_address = src_ptr;
    end else if (state_q == ST_WRITE) begin
      mem_address = dst_ptr;
      mem_wdata   = data_buf_q;
    end
    dbg_state    = state_q;
    dbg_word_idx = mem_address[ADDR_W+1:2];
  end

endmodule

// File: tb/tb_mem_dma_engine.sv
// Self-checking bench for mem_dma_engine with a word-addressed memory model.
module tb_mem_dma_engine;
  import mem_dma_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int EV_W   = 66;
  localparam logic [1:0] EV_WRITE = 2'd1;
  localparam logic [1:0] EV_DONE  = 2'd2;
  localparam logic [1:0] EV_ERROR = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start;
  logic [31:0]       src_addr;
  logic [31:0]       dst_addr;
  logic [CNT_W-1:0]  word_count;
  logic              busy;
  logic              done;
  logic              error;
  logic [31:0]       mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_read;
  logic              mem_write;
  dma_state_t        dbg_state;
  logic [ADDR_W-1:0] dbg_word_idx;
`ifdef MEM_DMA_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  mem_dma_engine #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .word_count   (word_count),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .dbg_state    (dbg_state),
    .dbg_word_idx (dbg_word_idx)
`ifdef MEM_DMA_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        init_mem;
  logic        pl_we;
  int          pl_idx;
  logic [31:0] pl_data;

  function automatic logic [31:0] fill(input int i);
    return (32'(i) * 32'h9E37_79B9) + 32'h0000_1234;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  assign mem_rdata = mem_read ? mem[widx(mem_address)] : 'z;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= fill(i);
    end else if (mem_write) begin
      mem[widx(mem_address)] <= mem_wdata;
    end else if (pl_we) begin
      mem[pl_idx] <= pl_data;
    end
  end

  // ---------------- scoreboard ----------------
  logic [EV_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [EV_W-1:0] act, input logic [EV_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain forward word copy on the shadow memory, up to limit words.
  task automatic model_copy(input logic [31:0] src, input logic [31:0] dst,
                            input int n, input int limit);
    logic [31:0] sum;
    logic [31:0] a_s;
    logic [31:0] a_d;
    logic [31:0] v;
    if (src[1:0] != 2'b00 || dst[1:0] != 2'b00) begin
      exp_q.push_back({EV_ERROR, 64'h0});
      return;
    end
    sum = 32'h0;
    for (int i = 0; i < n && i < limit; i++) begin
      a_s = src + 32'(4 * i);
      a_d = dst + 32'(4 * i);
      v = ref_mem[widx(a_s)];
      ref_mem[widx(a_d)] = v;
      sum = sum + v;
      exp_q.push_back({EV_WRITE, a_d, v});
    end
`ifndef MEM_DMA_CHECKSUM_EN
    sum = 32'h0;
`endif
    if (limit >= n) exp_q.push_back({EV_DONE, 32'h0, sum});
  endtask

  // Monitor: every write/done/error the DUT presents is matched in order.
  always @(negedge clk) begin
    logic [EV_W-1:0] act;
    logic [31:0]     csum;
    if (!reset) begin
      if (mem_read || mem_write) check("rw_exclusive", EV_W'(mem_read & mem_write), '0);
      if (mem_write || done || error) begin
`ifdef MEM_DMA_CHECKSUM_EN
        csum = checksum;
`else
        csum = 32'h0;
`endif
        if (mem_write)  act = {EV_WRITE, mem_address, mem_wdata};
        else if (done)  act = {EV_DONE, 32'h0, csum};
        else            act = {EV_ERROR, 64'h0};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %0h, expected none", act);
        end else begin
          check("mon_event", act, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    ref_mem[widx(addr)] = data;
    pl_we = 1'b1;
    pl_idx = widx(addr);
    pl_data = data;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int n);
    bit mis;
    int total;
    mis = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
    total = mis ? 1 : 2 * n + 1;
    model_copy(src, dst, n, n);
    start = 1'b1;
    src_addr = src;
    dst_addr = dst;
    word_count = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= total + 1; k++) begin
      check("busy", EV_W'(busy), EV_W'(!mis && k <= 2 * n));
      check("done", EV_W'(done), EV_W'(!mis && k == total));
      check("error", EV_W'(error), EV_W'(mis && k == 1));
      if (mis || n == 0) check("no_access", EV_W'(mem_read | mem_write), '0);
      if (k <= total) begin
        @(posedge clk); #1;
      end
    end
    check("queue_drained", EV_W'(exp_q.size()), '0);
  endtask

  task automatic check_mem(input string name);
    int diffs;
    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check(name, EV_W'(diffs), '0);
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_busy"}, EV_W'(busy), '0);
    check({name, "_done"}, EV_W'(done), '0);
    check({name, "_error"}, EV_W'(error), '0);
    check({name, "_rd"}, EV_W'(mem_read), '0);
    check({name, "_wr"}, EV_W'(mem_write), '0);
    check({name, "_addr"}, EV_W'(mem_address), '0);
    check({name, "_wdata"}, EV_W'(mem_wdata), '0);
    check({name, "_state"}, EV_W'(dbg_state), EV_W'(ST_IDLE));
`ifdef MEM_DMA_CHECKSUM_EN
    check({name, "_csum"}, EV_W'(checksum), '0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rs;
    logic [31:0] rd;
    int rn;
    reset = 1'b1;
    init_mem = 1'b1;
    pl_we = 1'b0;
    pl_idx = 0;
    pl_data = '0;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    word_count = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = fill(i);
    #1;
    check_idle_zero("reset");
    @(posedge clk); #1;
    init_mem = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic copy
    poke(32'h100, 32'h11);
    poke(32'h104, 32'h22);
    poke(32'h108, 32'h33);
    poke(32'h10C, 32'h44);
    run_xfer(32'h100, 32'h200, 4);
    check("basic_w0", EV_W'(mem[widx(32'h200)]), EV_W'(32'h11));
    check("basic_w1", EV_W'(mem[widx(32'h204)]), EV_W'(32'h22));
    check("basic_w2", EV_W'(mem[widx(32'h208)]), EV_W'(32'h33));
    check("basic_w3", EV_W'(mem[widx(32'h20C)]), EV_W'(32'h44));

    // Zero count
    run_xfer(32'h300, 32'h340, 0);

    // Misaligned source / destination
    run_xfer(32'h102, 32'h200, 2);
    run_xfer(32'h100, 32'h201, 2);
    check_mem("mem_after_basic");

    // Start while busy, then reset during the WRITE of word 2
    poke(32'h3000, 32'hC0DE_0001);
    poke(32'h3004, 32'hC0DE_0002);
    poke(32'h3008, 32'hC0DE_0003);
    poke(32'h300C, 32'hC0DE_0004);
    model_copy(32'h3000, 32'h4000, 4, 1);
    start = 1'b1;
    src_addr = 32'h3000;
    dst_addr = 32'h4000;
    word_count = CNT_W'(4);
    @(posedge clk); #1;
    src_addr = 32'h0;
    dst_addr = 32'h800;
    word_count = CNT_W'(2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    check("wr2_active", EV_W'(mem_write), EV_W'(1'b1));
    check("wr2_addr", EV_W'(mem_address), EV_W'(32'h4004));
    reset = 1'b1;
    #1;
    check_idle_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_w1", EV_W'(mem[widx(32'h4000)]), EV_W'(32'hC0DE_0001));
    check("abort_w2", EV_W'(mem[widx(32'h4004)]), EV_W'(fill(widx(32'h4004))));
    check("abort_queue", EV_W'(exp_q.size()), '0);
    exp_q.delete();
    check_mem("mem_after_abort");

    // Overlapping forward copy propagates the first word
    poke(32'h0, 32'hA5);
    run_xfer(32'h0, 32'h4, 3);
    check("ovl_w1", EV_W'(mem[1]), EV_W'(32'hA5));
    check("ovl_w2", EV_W'(mem[2]), EV_W'(32'hA5));
    check("ovl_w3", EV_W'(mem[3]), EV_W'(32'hA5));

`ifdef MEM_DMA_CHECKSUM_EN
    // Checksum wraps modulo 2^32 and holds after done
    poke(32'h5000, 32'h1);
    poke(32'h5004, 32'h2);
    poke(32'h5008, 32'h3);
    poke(32'h500C, 32'hFFFF_FFFF);
    run_xfer(32'h5000, 32'h6000, 4);
    check("csum_hold", EV_W'(checksum), EV_W'(32'h5));
`endif

    // Pointer wrap past 2^32
    run_xfer(32'hFFFF_FFF8, 32'h20, 4);

    // Randomized transfers in a small window so overlaps occur
    for (int t = 0; t < 25; t++) begin
      rs = 32'h1000 + 32'($urandom_range(0, 63) * 4);
      rd = 32'h1000 + 32'($urandom_range(0, 63) * 4);
      rn = $urandom_range(0, 10);
      if ($urandom_range(0, 7) == 0) rs = rs | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) rd = rd | 32'($urandom_range(1, 3));
      run_xfer(rs, rd, rn);
    end
    check_mem("mem_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
